fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width; word addresses SHALL be ADDR_WIDTH-2 bits.
REQ-002 The block SHALL have parameter RESET_ADDR, default 0, meaning the byte address of the first fetch; bits [1:0] SHALL be ignored.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 2, meaning the capacity of the response buffer and the maximum number of requests in flight.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; one clock domain; all state updates on posedge clk.
REQ-005 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port mem_req_valid, output, 1 bit, meaning a fetch request is presented.
REQ-007 The block SHALL have port mem_req_ready, input, 1 bit, meaning memory accepts the request this cycle.
REQ-008 The block SHALL have port mem_req_addr, output, ADDR_WIDTH-2 bits, meaning the word address of the request.
REQ-009 The block SHALL have port mem_rsp_valid, input, 1 bit, meaning response data are present; responses return in order, at least 1 cycle after acceptance, with no backpressure.
REQ-010 The block SHALL have port mem_rsp_data, input, 32 bits, meaning the instruction word.
REQ-011 The block SHALL have port redirect_valid, input, 1 bit, meaning the fetch path is redirected.
REQ-012 The block SHALL have port redirect_addr, input, ADDR_WIDTH-2 bits, meaning the new word address.
REQ-013 The block SHALL have port out_valid, output, 1 bit, meaning out_insn holds a valid bundle for the read stage.
REQ-014 The block SHALL have port out_ready, input, 1 bit, meaning the read stage accepts the bundle this cycle.
REQ-015 The block SHALL have port out_insn, output, stage::InsnBundle, with addr = word address and insn = instruction.

Function
REQ-016 The pc register SHALL hold the next word address to request, and mem_req_addr SHALL equal pc.
REQ-017 mem_req_valid SHALL be high iff state==RUN, redirect_valid==0, and outstanding+fifo_count < FIFO_DEPTH (credit rule).
REQ-018 A request SHALL be accepted when mem_req_valid && mem_req_ready are both high; on acceptance pc SHALL increment by 1, modulo 2^(ADDR_WIDTH-2) (wrap to 0), and outstanding SHALL increment.
REQ-019 A response in RUN SHALL be pushed into the FIFO together with its request address, tracked by an in-order address queue or an equivalent mechanism.
REQ-020 Each response SHALL decrement outstanding.
REQ-021 out_valid SHALL equal FIFO non-empty, and out_insn SHALL equal the FIFO head.
REQ-022 The FIFO head SHALL pop on out_valid && out_ready.
REQ-023 Push and pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full.
REQ-024 The FIFO SHALL never overflow, which the credit rule guarantees.
REQ-025 The FSM SHALL have exactly two states, RUN and DRAIN.
REQ-026 On redirect_valid, pc SHALL load redirect_addr, the FIFO SHALL flush, and drop_cnt SHALL load the in-flight count (outstanding plus any request accepted that cycle, minus any response that cycle).
REQ-027 On redirect_valid, the state SHALL go to DRAIN if the new drop_cnt is nonzero and to RUN otherwise.
REQ-028 In DRAIN, each response SHALL be discarded and decrement drop_cnt, and no requests SHALL issue.
REQ-029 In DRAIN, when drop_cnt reaches 0 the state SHALL return to RUN, and the first request SHALL issue the following cycle.
REQ-030 A redirect received while in DRAIN SHALL reload pc and recompute drop_cnt per REQ-026.
REQ-031 A pop in the same cycle as a redirect SHALL count as a completed transfer, and the remaining entries SHALL be flushed.
REQ-032 A response in the same cycle as a redirect SHALL be discarded and SHALL be excluded from drop_cnt.
REQ-033 A request accepted in the same cycle as a redirect SHALL be impossible, because redirect gates mem_req_valid.
REQ-034 Latency SHALL be: a response at cycle N appears on out_valid at cycle N+1.

Reset
REQ-035 While rst is high, the block SHALL load pc=RESET_ADDR[ADDR_WIDTH-1:2], state=RUN, outstanding=0, drop_cnt=0, and FIFO empty.
REQ-036 While rst is high, mem_req_valid and out_valid SHALL be 0.
REQ-037 Reset mid-operation SHALL discard all in-flight state; the memory is reset together with the block.

Structure
REQ-038 InsnBundle and a FetchState enum {RUN, DRAIN} SHALL reside in package stage; no other shared constants are needed.
REQ-039 The FIFO SHALL be a separate sub-module, insn_fifo, parameterised by depth, with push/pop/flush inputs and full/empty/count outputs.

Verification
REQ-040 The bench SHALL cover: reset release, mem_req_ready=1, 1-cycle memory latency, out_ready=1 -> requests to word addresses 0,1,2,...; out_insn.addr sequence is 0,1,2 with one bundle per cycle.
REQ-041 The bench SHALL cover: out_ready=0 for 10 cycles -> exactly 2 requests issue, out_valid stays 1 with addr 0, no overflow; out_ready=1 -> 0,1,2 delivered in order.
REQ-042 The bench SHALL cover: redirect_addr=0x100 with 2 requests in flight -> state DRAIN, 2 responses dropped, next mem_req_addr=0x100, first output addr 0x100.
REQ-043 The bench SHALL cover: redirect in the same cycle as a response and a pop -> popped bundle counts, response dropped, FIFO empty the next cycle.
REQ-044 The bench SHALL cover: RESET_ADDR=0xFFFFFFF8 (ADDR_WIDTH=32) -> word addresses 0x3FFFFFFE, 0x3FFFFFFF, 0x00000000.
REQ-045 The bench SHALL cover: rst asserted mid-stream with 2 in flight -> next cycle mem_req_valid=0, out_valid=0, pc=RESET_ADDR word.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: the bundle handed to the read stage
// and the two-state fetch FSM encoding.
package stage;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } FetchState;

    // Word address of the instruction plus the instruction itself.
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] insn;
    } InsnBundle;

endpackage

// File: rtl/insn_fifo.sv
// Small circular FIFO holding fetched bundles. Flush empties it in one cycle;
// a pop and a push in the same cycle are allowed even when full.
module insn_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 62,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues sequential word fetches under a credit limit,
// buffers in-order responses with their addresses, and on redirect drops
// every response still in flight before fetching from the new address.
module fetch_stage
    import stage::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-3:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-3:0] redirect_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output InsnBundle             out_insn
);

    localparam int AW = ADDR_WIDTH - 2;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    FetchState     state;
    logic [AW-1:0] pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          req_fire;
    logic          rsp_keep;
    logic          pop;
    logic [AW-1:0] rsp_addr;
    InsnBundle     fifo_din;
    InsnBundle     fifo_dout;

    // Credit: never have more requests in flight than free FIFO slots.
    assign mem_req_valid = !rst && (state == RUN) && !redirect_valid &&
                           ((CW+1)'(outstanding) + (CW+1)'(fifo_count) < (CW+1)'(FIFO_DEPTH));
    assign mem_req_addr  = pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // In RUN every in-flight request is sequential from the oldest one, so
    // the returning response belongs to pc - outstanding.
    assign rsp_addr      = pc - AW'(outstanding);
    assign rsp_keep      = !rst && mem_rsp_valid && (state == RUN) && !redirect_valid;
    assign inflight_next = outstanding + CW'(req_fire) - CW'(mem_rsp_valid);

    assign fifo_din.addr = 30'(rsp_addr);
    assign fifo_din.insn = mem_rsp_data;

    assign out_valid     = !rst && !fifo_empty;
    assign out_insn      = fifo_dout;
    assign pop           = out_valid && out_ready;

    insn_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(InsnBundle))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Run/drain control, pc and in-flight accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_ADDR[ADDR_WIDTH-1:2];
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= inflight_next;
            if (redirect_valid) begin
                pc       <= redirect_addr;
                drop_cnt <= inflight_next;
                state    <= (inflight_next != '0) ? DRAIN : RUN;
            end else begin
                if (req_fire)
                    pc <= pc + AW'(1);
                if (state == DRAIN && mem_rsp_valid) begin
                    drop_cnt <= drop_cnt - CW'(1);
                    if (drop_cnt == CW'(1))
                        state <= RUN;
                end
            end
        end
    end

    // The credit rule must keep a kept response from landing in a full FIFO.
    assert property (@(posedge clk) disable iff (rst) !(rsp_keep && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import stage::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [29:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [29:0] redirect_addr = '0;
    logic        out_valid, out_ready = 1'b0;
    InsnBundle   out_insn;

    fetch_stage #(.ADDR_WIDTH(32), .RESET_ADDR(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn)
    );

    // Second instance near the top of the address space to see pc wrap.
    logic        rst2 = 1'b1, mrv2, mrsp2 = 1'b0, ov2;
    logic [29:0] maddr2;
    InsnBundle   oi2;
    fetch_stage #(.ADDR_WIDTH(32), .RESET_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_hi (
        .clk(clk), .rst(rst2),
        .mem_req_valid(mrv2), .mem_req_ready(1'b1), .mem_req_addr(maddr2),
        .mem_rsp_valid(mrsp2), .mem_rsp_data(32'h0),
        .redirect_valid(1'b0), .redirect_addr(30'h0),
        .out_valid(ov2), .out_ready(1'b1), .out_insn(oi2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the byte address.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [31:0] b;
        b = {a, 2'b00};
        return (b * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Reference model: requests in flight at the memory (live = still wanted),
    // expected bundles in delivery order, and the next address to fetch.
    typedef struct {
        logic [29:0] addr;
        int          due;
        bit          live;
    } mreq_t;

    mreq_t       mem_q[$];
    InsnBundle   exp_q[$];
    logic [29:0] model_pc = '0;
    int          cyc_n = 0;
    int          last_due = 0;
    int          delivered = 0;
    logic [29:0] deliv_addr[$];
    int          accepted_cnt = 0;

    // Per-cycle stimulus controls.
    bit          c_rst = 1, c_redir = 0, c_ready = 0, c_oready = 0;
    logic [29:0] c_raddr = '0;
    int          c_lat = 1;

    // Monitor: whenever a bundle is handed over, it must be the next expected one.
    initial forever begin
        @(negedge clk);
        #1;
        chk("out_valid", out_valid, !rst && exp_q.size() != 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_bundle actual addr=%0h expected none", out_insn.addr);
            end else begin
                InsnBundle e;
                e = exp_q.pop_front();
                chk("out_addr", out_insn.addr, e.addr);
                chk("out_insn", out_insn.insn, e.insn);
                delivered++;
                deliv_addr.push_back(out_insn.addr);
            end
        end
    end

    // One clock cycle: drive inputs, act as memory, check request side, update model.
    task automatic cyc();
        mreq_t       m;
        bit          rsp, rsp_live, acc;
        logic [29:0] ra;
        int          n_inflight, n_dead, n_fifo, lat;
        InsnBundle   b;
        @(negedge clk);
        rst            = c_rst;
        redirect_valid = c_redir;
        redirect_addr  = c_raddr;
        mem_req_ready  = c_ready;
        out_ready      = c_oready;
        n_inflight = mem_q.size();
        n_fifo     = exp_q.size();
        n_dead     = 0;
        foreach (mem_q[i]) if (!mem_q[i].live) n_dead++;
        rsp = 0; rsp_live = 0; ra = '0;
        if (!c_rst && mem_q.size() > 0 && mem_q[0].due <= cyc_n) begin
            m = mem_q.pop_front();
            rsp = 1; rsp_live = m.live; ra = m.addr;
            mem_rsp_data = mem_word(m.addr);
        end else begin
            mem_rsp_data = $urandom();
        end
        mem_rsp_valid = rsp;
        #2;
        chk("mem_req_valid", mem_req_valid,
            !c_rst && !c_redir && n_dead == 0 && (n_inflight + n_fifo < DEPTH));
        if (!c_rst) chk("mem_req_addr", mem_req_addr, model_pc);
        acc = mem_req_valid && mem_req_ready;
        if (c_rst) begin
            mem_q.delete();
            exp_q.delete();
            model_pc = '0;
            last_due = cyc_n;
        end else begin
            if (acc) begin
                lat    = (c_lat != 0) ? c_lat : int'($urandom_range(1, 3));
                m.addr = model_pc;
                m.live = 1;
                m.due  = (cyc_n + lat > last_due + 1) ? cyc_n + lat : last_due + 1;
                last_due = m.due;
                mem_q.push_back(m);
                model_pc = model_pc + 30'd1;
                accepted_cnt++;
            end
            if (rsp && rsp_live && !c_redir) begin
                b.addr = ra;
                b.insn = mem_word(ra);
                exp_q.push_back(b);
            end
            if (c_redir) begin
                exp_q.delete();
                for (int i = 0; i < mem_q.size(); i++) begin
                    m = mem_q[i];
                    m.live = 0;
                    mem_q[i] = m;
                end
                model_pc = c_raddr;
            end
        end
        cyc_n++;
    endtask

    task automatic do_reset(input int n);
        c_rst = 1; c_redir = 0;
        repeat (n) cyc();
        c_rst = 0;
    endtask

    // Wrap-around instance: three requests 3FFFFFFE, 3FFFFFFF, 0.
    logic [29:0] got2[$];
    logic [29:0] first_out2 = '1;
    bit          seen_out2 = 0;
    bit          done2 = 0;
    initial begin
        bit pend = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rst2  = (k < 2);
            mrsp2 = pend;
            #1;
            if (!rst2 && ov2 && !seen_out2) begin
                first_out2 = oi2.addr;
                seen_out2  = 1;
            end
            if (!rst2 && mrv2) got2.push_back(maddr2);
            pend = !rst2 && mrv2;
        end
        chk("wrap_req_count_ge3", got2.size() >= 3, 1);
        if (got2.size() >= 3) begin
            chk("wrap_req0", got2[0], 30'h3FFF_FFFE);
            chk("wrap_req1", got2[1], 30'h3FFF_FFFF);
            chk("wrap_req2", got2[2], 30'h0000_0000);
        end
        chk("wrap_first_out", first_out2, 30'h3FFF_FFFE);
        done2 = 1;
    end

    initial begin
        int d0, a0;
        // Streaming from reset: addresses 0,1,2 in order.
        do_reset(3);
        c_ready = 1; c_oready = 1; c_lat = 1;
        d0 = delivered;
        repeat (15) cyc();
        chk("stream_count_ge3", (delivered - d0) >= 3, 1);
        if (delivered - d0 >= 3) begin
            chk("stream_addr0", deliv_addr[d0],     30'd0);
            chk("stream_addr1", deliv_addr[d0 + 1], 30'd1);
            chk("stream_addr2", deliv_addr[d0 + 2], 30'd2);
        end

        // Backpressure: only two requests fit, then in-order delivery.
        do_reset(2);
        c_ready = 1; c_oready = 0; c_lat = 1;
        a0 = accepted_cnt;
        repeat (10) cyc();
        chk("stall_requests", accepted_cnt - a0, 2);
        chk("stall_head_addr", out_insn.addr, 30'd0);
        d0 = delivered;
        c_oready = 1;
        repeat (6) cyc();
        if (delivered - d0 >= 3) begin
            chk("resume_addr0", deliv_addr[d0],     30'd0);
            chk("resume_addr1", deliv_addr[d0 + 1], 30'd1);
            chk("resume_addr2", deliv_addr[d0 + 2], 30'd2);
        end else chk("resume_count_ge3", delivered - d0, 3);

        // Redirect with two requests in flight: both dropped, restart at 0x100.
        do_reset(2);
        c_ready = 1; c_oready = 0; c_lat = 3;
        repeat (2) cyc();
        c_redir = 1; c_raddr = 30'h100;
        cyc();
        c_redir = 0;
        repeat (2) cyc();
        chk("drain_no_request", mem_req_valid, 0);
        cyc();
        chk("restart_addr", mem_req_addr, 30'h100);
        d0 = delivered;
        c_oready = 1;
        repeat (8) cyc();
        chk("redirect_first_out", (delivered > d0) ? deliv_addr[d0] : 30'h3FFF_FFFF, 30'h100);

        // Redirect in the same cycle as a response and a pop.
        do_reset(2);
        c_ready = 1; c_oready = 0;
        c_lat = 1; cyc();
        c_lat = 2; cyc();
        cyc();
        d0 = delivered;
        c_redir = 1; c_raddr = 30'h40; c_oready = 1;
        chk("pre_redirect_rsp_due", (mem_q.size() > 0) ? mem_q[0].due : -1, cyc_n);
        cyc();
        c_redir = 0;
        chk("pop_with_redirect", delivered - d0, 1);
        cyc();
        chk("flushed_after_redirect", out_valid, 0);
        repeat (5) cyc();

        // Randomised traffic with redirects, backpressure and occasional reset.
        c_lat = 0;
        for (int k = 0; k < 1500; k++) begin
            c_rst    = ($urandom_range(0, 199) == 0);
            c_redir  = ($urandom_range(0, 19) == 0);
            c_raddr  = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFC + 30'($urandom_range(0, 3))
                                                    : 30'($urandom());
            c_ready  = ($urandom_range(0, 3) != 0);
            c_oready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        c_rst = 0; c_redir = 0;

        // Reset mid-stream with two requests in flight.
        do_reset(2);
        c_ready = 1; c_oready = 1; c_lat = 3;
        for (int k = 0; k < 20 && mem_q.size() < 2; k++) cyc();
        c_rst = 1;
        cyc();
        cyc();
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        c_rst = 0;
        cyc();
        chk("rst_pc", mem_req_addr, 30'd0);
        repeat (10) cyc();

        chk("wrap_instance_done", done2, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
